// File: rtl/aes_pkg.sv
// Shared definitions for the AES command sequencer.
//   - AES register offsets relative to the accelerator base address
//   - STATE register idle encoding
//   - sequencer FSM state type
//   - write_offset(): register offset of the idx-th configuration write
package aes_pkg;

    localparam logic [7:0] AES_START = 8'h00;
    localparam logic [7:0] AES_STATE = 8'h01;
    localparam logic [7:0] AES_ADDR  = 8'h02;
    localparam logic [7:0] AES_LEN   = 8'h04;
    localparam logic [7:0] AES_CTR   = 8'h10;
    localparam logic [7:0] AES_KEY0  = 8'h20;

    localparam logic [1:0] AES_STATE_IDLE = 2'b00;

    // ADDR(2) + LEN(2) + CTR(16) + KEY0(16)
    localparam logic [5:0] SEQ_NUM_WRITES = 6'd36;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WRITE,
        SEQ_START,
        SEQ_GAP,
        SEQ_POLL,
        SEQ_DONE
    } seq_state_e;

    // Write order: ADDR[0..1], LEN[0..1], CTR[0..15], KEY0[0..15]
    function automatic logic [7:0] write_offset(input logic [5:0] idx);
        logic [7:0] i8;
        i8 = {2'b00, idx};
        if (idx < 6'd2)       return AES_ADDR + i8;
        else if (idx < 6'd4)  return AES_LEN  + (i8 - 8'd2);
        else if (idx < 6'd20) return AES_CTR  + (i8 - 8'd4);
        else                  return AES_KEY0 + (i8 - 8'd20);
    endfunction

endpackage

// File: rtl/aes_bus_master.sv
// Single-transaction stb/ack engine for the AES byte-wide MMIO port.
// A request is taken only while the bus is idle (stb low); stb/wr/addr/data
// are registered and held until ack is seen, then stb drops for at least one
// cycle. cpl_o pulses in the ack cycle with the read data passed through.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i, req_wr_i,
//   req_addr_i, req_wdata_i  transaction request
//   busy_o                   transaction outstanding (stb high)
//   cpl_o, rdata_o           completion pulse and read data
//   stb_o, wr_o, addr_o,
//   data_out_o, data_in_i,
//   ack_i                    MMIO bus
module aes_bus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        req_wr_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        busy_o,
    output logic        cpl_o,
    output logic [7:0]  rdata_o,
    output logic        stb_o,
    output logic        wr_o,
    output logic [15:0] addr_o,
    output logic [7:0]  data_out_o,
    input  logic [7:0]  data_in_i,
    input  logic        ack_i
);

    logic        stb_q, stb_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    always_comb begin
        stb_d  = stb_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (stb_q) begin
            if (ack_i) stb_d = 1'b0;
        end else if (req_i) begin
            stb_d  = 1'b1;
            wr_d   = req_wr_i;
            addr_d = req_addr_i;
            data_d = req_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 16'h0000;
            data_q <= 8'h00;
        end else begin
            stb_q  <= stb_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // ack while stb is low is not a completion
    assign cpl_o      = stb_q & ack_i;
    assign rdata_o    = data_in_i;
    assign busy_o     = stb_q;
    assign stb_o      = stb_q;
    assign wr_o       = wr_q;
    assign addr_o     = addr_q;
    assign data_out_o = data_q;

endmodule

// File: rtl/aes_cmd_seq.sv
// AES command sequencer: programs one encryption job into the AES register
// block over the byte-wide MMIO port, issues START, polls STATE until idle
// and pulses done (with err on poll timeout).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   job_valid, job_ready           job handshake
//   job_addr, job_len,
//   job_ctr, job_key               job fields, captured on accept
//   done, err                      completion / timeout pulses
//   stb, wr, addr, data_out,
//   data_in, ack                   MMIO bus to aes_top
//
// state | meaning
// IDLE  | ready for a job; accept issues ADDR byte 0 directly from inputs
// WRITE | 36 configuration byte writes, write index selects register/byte
// START | write 8'h01 to START
// GAP   | POLL_GAP idle bus cycles, then issue STATE read
// POLL  | wait for STATE read ack; idle -> DONE, timeout -> DONE+err
// DONE  | one-cycle done (and err) pulse
module aes_cmd_seq
    import aes_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hff00,
    parameter int unsigned POLL_GAP  = 4,
    parameter logic [15:0] MAX_POLLS = 16'hffff
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [15:0]  job_addr,
    input  logic [15:0]  job_len,
    input  logic [127:0] job_ctr,
    input  logic [127:0] job_key,
    output logic         done,
    output logic         err,
    output logic         stb,
    output logic         wr,
    output logic [15:0]  addr,
    output logic [7:0]   data_out,
    input  logic [7:0]   data_in,
    input  logic         ack
);

    // The gap timer issues the read on its terminal count, so loading
    // POLL_GAP-1 yields exactly POLL_GAP stb-low cycles between polls.
    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

    seq_state_e   state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [15:0]  poll_q, poll_d;
    logic [15:0]  gap_q, gap_d;
    logic         err_q, err_d;
    logic [15:0]  jaddr_q, jaddr_d;
    logic [15:0]  jlen_q, jlen_d;
    logic [127:0] jctr_q, jctr_d;
    logic [127:0] jkey_q, jkey_d;

    logic         req;
    logic         req_wr;
    logic [15:0]  req_addr;
    logic [7:0]   req_wdata;
    logic         bus_busy;
    logic         bus_cpl;
    logic [7:0]   bus_rdata;

    logic [35:0][7:0] job_bytes;
    logic [5:0]       wr_idx;
    logic [15:0]      poll_inc;
    logic             aes_idle;

    // In IDLE the first write is launched from the live inputs so that stb
    // rises the cycle right after accept.
    always_comb begin
        if (state_q == SEQ_IDLE) begin
            job_bytes = {job_key, job_ctr, job_len, job_addr};
            wr_idx    = 6'd0;
        end else begin
            job_bytes = {jkey_q, jctr_q, jlen_q, jaddr_q};
            wr_idx    = idx_q;
        end
    end

    assign poll_inc = (poll_q == 16'hffff) ? poll_q : poll_q + 16'd1;
    assign aes_idle = (bus_rdata & 8'h03) == {6'b000000, AES_STATE_IDLE};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        err_d     = err_q;
        jaddr_d   = jaddr_q;
        jlen_d    = jlen_q;
        jctr_d    = jctr_q;
        jkey_d    = jkey_q;
        req       = 1'b0;
        req_wr    = 1'b1;
        req_addr  = BASE_ADDR + {8'h00, write_offset(wr_idx)};
        req_wdata = job_bytes[wr_idx];

        case (state_q)
            SEQ_IDLE: begin
                if (job_valid) begin
                    jaddr_d = job_addr;
                    jlen_d  = job_len;
                    jctr_d  = job_ctr;
                    jkey_d  = job_key;
                    idx_d   = 6'd0;
                    poll_d  = 16'h0000;
                    err_d   = 1'b0;
                    req     = 1'b1;
                    state_d = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                req = ~bus_busy;
                if (bus_cpl) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == SEQ_NUM_WRITES - 6'd1) state_d = SEQ_START;
                end
            end
            SEQ_START: begin
                req       = ~bus_busy;
                req_addr  = BASE_ADDR + {8'h00, AES_START};
                req_wdata = 8'h01;
                if (bus_cpl) begin
                    gap_d   = GAP_LOAD;
                    state_d = SEQ_GAP;
                end
            end
            SEQ_GAP: begin
                req_wr    = 1'b0;
                req_addr  = BASE_ADDR + {8'h00, AES_STATE};
                req_wdata = 8'h00;
                if (gap_q == 16'h0000) begin
                    req     = 1'b1;
                    state_d = SEQ_POLL;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            SEQ_POLL: begin
                if (bus_cpl) begin
                    poll_d = poll_inc;
                    if (aes_idle) begin
                        state_d = SEQ_DONE;
                    end else if (poll_inc == MAX_POLLS) begin
                        err_d   = 1'b1;
                        state_d = SEQ_DONE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = SEQ_GAP;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            idx_q   <= 6'd0;
            poll_q  <= 16'h0000;
            gap_q   <= 16'h0000;
            err_q   <= 1'b0;
            jaddr_q <= 16'h0000;
            jlen_q  <= 16'h0000;
            jctr_q  <= 128'h0;
            jkey_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            jaddr_q <= jaddr_d;
            jlen_q  <= jlen_d;
            jctr_q  <= jctr_d;
            jkey_q  <= jkey_d;
        end
    end

    assign job_ready = (state_q == SEQ_IDLE);
    assign done      = (state_q == SEQ_DONE);
    assign err       = done & err_q;

    aes_bus_master u_bus (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .req_wr_i   (req_wr),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .busy_o     (bus_busy),
        .cpl_o      (bus_cpl),
        .rdata_o    (bus_rdata),
        .stb_o      (stb),
        .wr_o       (wr),
        .addr_o     (addr),
        .data_out_o (data_out),
        .data_in_i  (data_in),
        .ack_i      (ack)
    );

endmodule

// File: tb/tb_aes_cmd_seq.sv
// Scoreboard bench for aes_cmd_seq: stimulus pushes the expected bus
// transactions and done/err results; a negedge monitor pops and compares.
module tb_aes_cmd_seq;

    localparam logic [15:0] BASE = 16'hff00;
    localparam int          GAP  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [15:0]  job_addr = '0;
    logic [15:0]  job_len = '0;
    logic [127:0] job_ctr = '0;
    logic [127:0] job_key = '0;
    logic         done, err, stb, wr, ack;
    logic [15:0]  addr;
    logic [7:0]   data_out, data_in;

    aes_cmd_seq #(.BASE_ADDR(BASE), .POLL_GAP(GAP), .MAX_POLLS(16'd4)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_addr(job_addr), .job_len(job_len), .job_ctr(job_ctr), .job_key(job_key),
        .done(done), .err(err), .stb(stb), .wr(wr), .addr(addr),
        .data_out(data_out), .data_in(data_in), .ack(ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int         wait_cycles = 0;
    logic       spur_ack = 1'b0;
    int         wcnt = 0;
    logic [1:0] resp_arr [8];
    int         resp_n = 0;
    logic [1:0] stuck_state = 2'b00;
    int         resp_idx = 0;

    assign ack     = (stb && (wcnt >= wait_cycles)) || spur_ack;
    assign data_in = {6'b0, (resp_idx < resp_n) ? resp_arr[resp_idx] : stuck_state};

    always @(posedge clk) begin
        if (rst) begin
            wcnt     <= 0;
            resp_idx <= 0;
        end else begin
            wcnt <= (stb && !ack) ? wcnt + 1 : 0;
            if (stb && ack && !wr) resp_idx <= resp_idx + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t exp_bus[$];
    logic exp_done[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    task automatic push_job(input logic [15:0] a, input logic [15:0] l,
                            input logic [127:0] c, input logic [127:0] k,
                            input int nreads, input logic e);
        for (int i = 0; i < 2; i++)  exp_bus.push_back('{1'b1, BASE + 16'(2 + i), a[8*i +: 8]});
        for (int i = 0; i < 2; i++)  exp_bus.push_back('{1'b1, BASE + 16'(4 + i), l[8*i +: 8]});
        for (int i = 0; i < 16; i++) exp_bus.push_back('{1'b1, BASE + 16'(16 + i), c[8*i +: 8]});
        for (int i = 0; i < 16; i++) exp_bus.push_back('{1'b1, BASE + 16'(32 + i), k[8*i +: 8]});
        exp_bus.push_back('{1'b1, BASE, 8'h01});
        for (int r = 0; r < nreads; r++) exp_bus.push_back('{1'b0, BASE + 16'd1, 8'h00});
        exp_done.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int          n_txn = 0;
    int          done_cnt = 0;
    int          start_rise_cyc = -1;
    logic [15:0] log_addr [512];
    logic [7:0]  log_data [512];
    logic        pend = 1'b0, prev_ack = 1'b0, prev_stb = 1'b0, last_read = 1'b0;
    logic        p_wr;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    int          hold_len = 0, low_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 0; prev_ack = 0; prev_stb = 0; last_read = 0;
            hold_len = 0; low_len = 0;
        end else begin
            if (prev_ack) chk("gap_after_ack", stb, 1'b0);
            if (pend) chk("hold_stable", {stb, wr, addr, data_out}, {1'b1, p_wr, p_addr, p_data});
            if (stb) begin
                if (!prev_stb) begin
                    if (!wr && last_read) chk("poll_gap", low_len, GAP);
                    if (wr && addr == BASE) start_rise_cyc = cyc;
                end
                hold_len = prev_stb ? hold_len + 1 : 1;
                low_len  = 0;
                if (ack) begin
                    chk("hold_len", hold_len, wait_cycles + 1);
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_txn", {wr, addr}, 17'h0);
                    end else begin
                        txn_t e;
                        e = exp_bus.pop_front();
                        chk("bus_wr", wr, e.wr);
                        chk("bus_addr", addr, e.addr);
                        if (e.wr) chk("bus_data", data_out, e.data);
                    end
                    log_addr[n_txn & 511] = addr;
                    log_data[n_txn & 511] = data_out;
                    n_txn++;
                    last_read = !wr;
                    pend = 0;
                end else begin
                    pend = 1; p_wr = wr; p_addr = addr; p_data = data_out;
                end
            end else begin
                low_len++;
                pend = 0;
            end
            prev_ack = stb && ack;
            prev_stb = stb;
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
                else chk("done_err", err, exp_done.pop_front());
            end else if (err) begin
                chk("err_without_done", err, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; job_valid = 1'b0; spur_ack = 1'b0;
        tick(); tick();
        chk("reset_outputs", {job_ready, done, err, stb, wr, addr, data_out},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00});
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic drive_job(input logic [15:0] a, input logic [15:0] l,
                             input logic [127:0] c, input logic [127:0] k);
        job_addr = a; job_len = l; job_ctr = c; job_key = k; job_valid = 1'b1;
    endtask

    localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;

    initial begin
        int t_acc, base, k;

        // 1: zero-wait slave, STATE busy x3 then idle
        wait_cycles = 0;
        resp_arr[0] = 2'b01; resp_arr[1] = 2'b01; resp_arr[2] = 2'b01; resp_arr[3] = 2'b00;
        resp_n = 4;
        do_reset();
        base = n_txn;
        push_job(16'h4000, 16'h0020, 128'h1, KEY1, 4, 1'b0);
        t_acc = cyc;
        drive_job(16'h4000, 16'h0020, 128'h1, KEY1);
        tick();
        job_valid = 1'b0;
        chk("first_stb_T+1", stb, 1'b1);
        chk("busy_ready_low", job_ready, 1'b0);
        wait_done(2000);
        chk("start_at_T+73", start_rise_cyc, t_acc + 73);
        chk("log_ff02", {log_addr[(base + 0) & 511], log_data[(base + 0) & 511]}, 24'hff0200);
        chk("log_ff03", {log_addr[(base + 1) & 511], log_data[(base + 1) & 511]}, 24'hff0340);
        chk("log_ff20", {log_addr[(base + 20) & 511], log_data[(base + 20) & 511]}, 24'hff2000);
        chk("log_ff2f", {log_addr[(base + 35) & 511], log_data[(base + 35) & 511]}, 24'hff2f0f);
        chk("log_ff00", {log_addr[(base + 36) & 511], log_data[(base + 36) & 511]}, 24'hff0001);
        chk("job1_txn_count", n_txn - base, 41);

        // 2: slave with 3 wait cycles
        wait_cycles = 3;
        resp_arr[0] = 2'b00; resp_n = 1;
        do_reset();
        push_job(16'hbeef, 16'h0100, 128'h00112233445566778899aabbccddeeff,
                 128'hcafef00d_12345678_9abcdef0_0badc0de, 1, 1'b0);
        drive_job(16'hbeef, 16'h0100, 128'h00112233445566778899aabbccddeeff,
                  128'hcafef00d_12345678_9abcdef0_0badc0de);
        tick();
        job_valid = 1'b0;
        wait_done(3000);

        // 3: STATE stuck busy, MAX_POLLS=4 -> 4 reads then done+err
        wait_cycles = 0;
        resp_n = 0; stuck_state = 2'b10;
        do_reset();
        push_job(16'h0001, 16'h0010, 128'h5, 128'h7, 4, 1'b1);
        drive_job(16'h0001, 16'h0010, 128'h5, 128'h7);
        tick();
        job_valid = 1'b0;
        wait_done(2000);
        chk("timeout_err_pulse", {done, err}, 2'b11);

        // 4: job_valid held through a job, fields change mid-job
        stuck_state = 2'b00;
        resp_arr[0] = 2'b00; resp_arr[1] = 2'b00; resp_n = 2;
        do_reset();
        push_job(16'haaaa, 16'h0040, 128'h11, 128'h22, 1, 1'b0);
        push_job(16'h1234, 16'h0000, 128'hdeadbeef_00000000_0000ffff_76543210,
                 128'h55aa55aa_33cc33cc_0ff00ff0_a5a5a5a5, 1, 1'b0);
        drive_job(16'haaaa, 16'h0040, 128'h11, 128'h22);
        for (int i = 0; i < 5; i++) tick();
        drive_job(16'h1234, 16'h0000, 128'hdeadbeef_00000000_0000ffff_76543210,
                  128'h55aa55aa_33cc33cc_0ff00ff0_a5a5a5a5);
        wait_done(2000);
        chk("ready_low_in_done", job_ready, 1'b0);
        tick();
        chk("ready_after_done", {job_ready, stb}, 2'b10);
        tick();
        chk("second_job_started", {job_ready, stb}, 2'b01);
        job_valid = 1'b0;
        wait_done(2000);

        // 5: reset while stb high during write index 10
        wait_cycles = 3;
        resp_arr[0] = 2'b00; resp_n = 1;
        do_reset();
        base = n_txn;
        push_job(16'h7777, 16'h0008, 128'h99, 128'h88, 1, 1'b0);
        drive_job(16'h7777, 16'h0008, 128'h99, 128'h88);
        tick();
        job_valid = 1'b0;
        k = 0;
        while (!(stb && (n_txn - base) == 10) && k < 500) begin
            tick();
            k++;
        end
        chk("reached_write10", {stb, 32'(n_txn - base)}, {1'b1, 32'd10});
        rst = 1'b1;
        tick();
        chk("rst_drops_stb", {stb, job_ready, done}, 3'b010);
        rst = 1'b0;
        exp_bus.delete();
        exp_done.delete();
        wait_cycles = 0;
        base = n_txn;
        push_job(16'h0202, 16'h0303, 128'h4, 128'h6, 1, 1'b0);
        drive_job(16'h0202, 16'h0303, 128'h4, 128'h6);
        tick();
        job_valid = 1'b0;
        wait_done(2000);
        chk("restart_addr_byte0", {log_addr[base & 511], log_data[base & 511]}, 24'hff0202);

        // 6: spurious ack while idle
        tick();
        k = done_cnt;
        spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spurious_ack_idle", {job_ready, done, stb}, 3'b100);
        end
        spur_ack = 1'b0;
        tick();
        chk("no_extra_done", done_cnt, k);

        chk("exp_bus_drained", exp_bus.size(), 0);
        chk("exp_done_drained", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
